dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the CPU load/store unit (port m0) and a secondary master such as DMA or debug (port m1). It picks one requester per cycle and drives the data memory's combinational read / clocked write interface from the winner. It returns a registered response (read data, write ack, range error) one cycle after grant, and supports a bounded lock for read-modify-write sequences.

## Interface
Parameters:
- MEM_SIZE, 1024: memory depth in 32-bit words; used for the address range check.
- LOCK_MAX, 16: maximum consecutive cycles one master may hold a lock (1..255).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- mN_req (N=0,1)  in  1  transaction request; held with its payload until mN_gnt.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  32  byte address; bits [1:0] ignored.
- mN_wdata  in  32  write data.
- mN_wmask  in  4  byte-lane write enables.
- mN_lock  in  1  request to keep ownership after this transaction.
- mN_gnt  out  1  combinational; transaction accepted this cycle.
- mN_rvalid  out  1  registered; one-cycle response pulse.
- mN_rdata  out  32  registered read data; 0 for writes and errors.
- mN_err  out  1  registered; valid with mN_rvalid; address out of range.
- mem_addr, mem_wdata, mem_wmask  out  32/32/4  forwarded from the winner; 0 when idle.
- mem_ren, mem_wen  out  1  strobes for the winner; 0 when idle or on error.
- mem_rdata  in  32  combinational memory read data.
- mem_rvalid  in  1  unused beyond an assertion check (must equal mem_ren).

## Operation
- State machine with states IDLE, LOCK0 and LOCK1. Reset state is IDLE.
- IDLE, winner selection:
  - If only one master requests, that master wins.
  - If both request, the master not granted most recently wins (pointer `last`).
- LOCKN: only mN can be granted. m(1-N) sees gnt=0 even while requesting.
- Grant rules:
  - gnt is asserted for the winner whenever its req=1.
  - mem_* signals are driven from the winner in the same cycle.
  - `last` updates to the winner on every grant.
- Lock entry: IDLE → LOCKN when mN is granted with mN_lock=1. The lock counter loads to 1.
- Lock exit, back to IDLE, when any of the following holds:
  - mN is granted with mN_lock=0. That transaction still completes.
  - mN_req=0 for one cycle while in LOCKN.
  - The counter reaches LOCK_MAX. The exit is forced and takes effect on the next edge. A grant in that cycle is still honoured.
- Lock counter: increments each cycle in LOCKN and saturates at LOCK_MAX.
- Range check: word address mN_addr[31:2] ≥ MEM_SIZE is an error.
  - gnt is still asserted, so the master is not hung.
  - mem_ren and mem_wen stay 0.
  - The response carries err=1 and rdata=0.
- Response: every grant produces exactly one mN_rvalid pulse on the following cycle, to the granted master only.
  - Reads return mem_rdata sampled at the grant-cycle edge.
  - Writes return rdata=0 and err=0 as an acknowledgement.

## Timing
- Grant and memory drive: combinational, cycle T.
- Write commit: posedge ending cycle T.
- Response: rvalid, rdata and err are high in cycle T+1 for exactly one cycle.
- Back-to-back throughput: one transaction per cycle. A read at T+1 after a write at T to the same word returns the new data.
- Reset values: state=IDLE, last=1 (m0 wins the first contention), lock counter=0.
- Outputs during reset: all mN_rvalid/mN_err=0, mN_rdata=0, mN_gnt=0, mem_ren/mem_wen=0.
- Reset mid-operation:
  - A pending response is dropped and the lock is cleared.
  - A write granted in the cycle reset asserts is not guaranteed to commit.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin selection in IDLE, as described above.
- DMEM_ARB_RR_EN undefined: fixed priority, m0 always wins contention in IDLE. The `last` pointer is not implemented. Locking and the LOCK_MAX timeout behave identically in both configurations.

## Test plan
- Single read: m0 reads word 5 preloaded with 0xDEADBEEF → m0_gnt at T, m0_rvalid at T+1 with rdata=0xDEADBEEF, err=0.
- Contention after reset: both masters request continuously → grants alternate m0, m1, m0, … With DMEM_ARB_RR_EN undefined, m0 is granted every cycle.
- Write then read: m1 writes 0x11223344 with wmask=4'b0101 to word 3 (old value 0xAABBCCDD), then reads it back → 0xAA22CC44.
- Lock: m1 is granted with lock=1, then issues 3 more locked transactions while m0 requests → m0_gnt=0 for those cycles. m0 is granted on the cycle after m1's lock=0 transaction.
- Lock timeout with LOCK_MAX=4: m1 holds lock and req high → m0 is granted within 5 cycles of lock entry.
- Out of range: m0 reads byte address 0x1000 with MEM_SIZE=1024 → m0_gnt=1, mem_ren=0, and at T+1 m0_rvalid=1, err=1, rdata=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Per-master request/response bundle for dmem_arbiter.
// Handshake: the master raises req with we/addr/wdata/wmask/lock and holds them
// stable until gnt is seen high in the same cycle (T). That transaction is then
// accepted, and rvalid pulses for exactly one cycle in T+1 carrying rdata/err.
// gnt is combinational from req; rvalid/rdata/err are registered.
interface dmem_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        lock;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, wdata, wmask, lock,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata, wmask, lock,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between m0 (LSU) and m1 (DMA/debug), with bounded locking.
// DMEM_ARB_RR_EN selects round-robin tie-break in IDLE; otherwise m0 has fixed priority.
module dmem_arbiter #(
   parameter int unsigned MEM_SIZE = 1024,
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave m0,
   dmem_arbiter_if.slave m1,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_wmask,
   output logic          mem_ren,
   output logic          mem_wen,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_rvalid,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

   state_t      state_q, state_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic        own0, own1;
   logic        gnt0, gnt1;
   logic        tie_m1;
   logic [31:0] word0, word1;
   logic        oor0, oor1;

   logic        rvalid0_q, rvalid1_q;
   logic        err0_q, err1_q;
   logic [31:0] rdata0_q, rdata1_q;

   assign word0 = {2'b00, m0.addr[31:2]};
   assign word1 = {2'b00, m1.addr[31:2]};
   assign oor0  = (word0 >= MEM_SIZE);
   assign oor1  = (word1 >= MEM_SIZE);

`ifdef DMEM_ARB_RR_EN
   // last_q = 1 when m1 held the most recent grant; resets to 1 so m0 wins first.
   logic last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (gnt0) begin
         last_q <= 1'b0;
      end else if (gnt1) begin
         last_q <= 1'b1;
      end
   end

   assign tie_m1 = ~last_q;
`else
   assign tie_m1 = 1'b0;
`endif

   // Ownership: who may be granted this cycle if it requests.
   always_comb begin
      own0 = 1'b0;
      own1 = 1'b0;
      case (state_q)
         IDLE: begin
            own0 = m0.req & ~(m1.req & tie_m1);
            own1 = m1.req & ~own0;
         end
         LOCK0:   own0 = 1'b1;
         LOCK1:   own1 = 1'b1;
         default: begin
            own0 = 1'b0;
            own1 = 1'b0;
         end
      endcase
   end

   assign gnt0 = rst_n & own0 & m0.req;
   assign gnt1 = rst_n & own1 & m1.req;

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         IDLE: begin
            lock_cnt_d = '0;
            if (gnt0 && m0.lock) begin
               state_d    = LOCK0;
               lock_cnt_d = 8'd1;
            end else if (gnt1 && m1.lock) begin
               state_d    = LOCK1;
               lock_cnt_d = 8'd1;
            end
         end
         LOCK0: begin
            if (!m0.req || !m0.lock || (lock_cnt_q >= LOCK_LIMIT)) begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + 8'd1;
            end
         end
         LOCK1: begin
            if (!m1.req || !m1.lock || (lock_cnt_q >= LOCK_LIMIT)) begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign dbg_state = state_q;

   // Out-of-range requests are still granted but never strobe the memory.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      if (gnt0) begin
         mem_addr  = m0.addr;
         mem_wdata = m0.wdata;
         mem_wmask = m0.wmask;
         mem_ren   = ~m0.we & ~oor0;
         mem_wen   = m0.we & ~oor0;
      end else if (gnt1) begin
         mem_addr  = m1.addr;
         mem_wdata = m1.wdata;
         mem_wmask = m1.wmask;
         mem_ren   = ~m1.we & ~oor1;
         mem_wen   = m1.we & ~oor1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0_q <= 1'b0;
         err0_q    <= 1'b0;
         rdata0_q  <= '0;
         rvalid1_q <= 1'b0;
         err1_q    <= 1'b0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= gnt0;
         err0_q    <= gnt0 & oor0;
         rdata0_q  <= (gnt0 && !m0.we && !oor0) ? mem_rdata : '0;
         rvalid1_q <= gnt1;
         err1_q    <= gnt1 & oor1;
         rdata1_q  <= (gnt1 && !m1.we && !oor1) ? mem_rdata : '0;
      end
   end

   assign m0.gnt    = gnt0;
   assign m0.rvalid = rvalid0_q;
   assign m0.rdata  = rdata0_q;
   assign m0.err    = err0_q;
   assign m1.gnt    = gnt1;
   assign m1.rvalid = rvalid1_q;
   assign m1.rdata  = rdata1_q;
   assign m1.err    = err1_q;

   a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
   a_lock_bound: assert property (@(posedge clk) disable iff (!rst_n) lock_cnt_q <= LOCK_LIMIT);
   a_mem_rvalid: assert property (@(posedge clk) disable iff (!rst_n) mem_rvalid == mem_ren);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed multi-cycle sequences and random traffic
// checked against a transaction-level model of arbitration, locking and memory contents.
module tb_dmem_arbiter;
  localparam int unsigned MEM_SIZE = 1024;
  localparam int unsigned LOCK_MAX = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        lock;
  } req_t;

  typedef struct {
    req_t r0;
    req_t r1;
    logic g0;
    logic g1;
    logic ren;
    logic wen;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_ren, mem_wen, mem_rvalid;
  logic [1:0]  dbg_state;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .dbg_state (dbg_state)
  );

  // memory behind the arbiter: combinational read, byte-masked clocked write
  logic [31:0] mem [0:1023];
  assign mem_rdata  = mem[mem_addr[11:2]];
  assign mem_rvalid = mem_ren;
  always @(posedge clk) begin
    if (mem_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // reference model state and scoreboard
  logic [31:0] ref_mem [0:1023];
  int          owner;
  int          held;
  int          last;
  logic [32:0] exp0_q[$];
  logic [32:0] exp1_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        s_g0, s_g1, s_ren, s_wen;
  req_t        idle_r;
  vec_t        vt[9];
  req_t        pend0, pend1, a0, a1;
  bit          has0, has1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wmask, input logic lock);
    req_t r;
    r.req = req; r.we = we; r.addr = addr; r.wdata = wdata; r.wmask = wmask; r.lock = lock;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.req = 1'b1;
    r.we  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       r.addr = 32'($urandom_range(1024, 4095)) << 2;
      1:       r.addr = 32'hFFFF_FFFC;
      default: r.addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
    endcase
    r.wdata = $urandom;
    r.wmask = 4'($urandom_range(0, 15));
    r.lock  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drive(input req_t a, input req_t b);
    m0_if.req = a.req; m0_if.we = a.we; m0_if.addr = a.addr;
    m0_if.wdata = a.wdata; m0_if.wmask = a.wmask; m0_if.lock = a.lock;
    m1_if.req = b.req; m1_if.we = b.we; m1_if.addr = b.addr;
    m1_if.wdata = b.wdata; m1_if.wmask = b.wmask; m1_if.lock = b.lock;
  endtask

  // One cycle: drive at negedge, check grant/memory side, then the response after the edge.
  task automatic step(input req_t a, input req_t b);
    req_t        rq[2];
    int          w;
    logic [31:0] word, e_addr, e_wdata, rd;
    logic [3:0]  e_wmask;
    logic        oor, e_ren, e_wen;
    logic [32:0] e;
    rq[0] = a; rq[1] = b;
    drive(a, b);
    if (owner >= 0)             w = rq[owner].req ? owner : -1;
    else if (a.req && b.req)    w = RR ? 1 - last : 0;
    else if (a.req)             w = 0;
    else if (b.req)             w = 1;
    else                        w = -1;
    word = '0; oor = 1'b0;
    e_addr = '0; e_wdata = '0; e_wmask = '0; e_ren = 1'b0; e_wen = 1'b0;
    if (w >= 0) begin
      word    = rq[w].addr >> 2;
      oor     = (word >= MEM_SIZE);
      e_addr  = rq[w].addr;
      e_wdata = rq[w].wdata;
      e_wmask = rq[w].wmask;
      e_ren   = !rq[w].we && !oor;
      e_wen   = rq[w].we && !oor;
    end
    #1;
    s_g0 = m0_if.gnt; s_g1 = m1_if.gnt; s_ren = mem_ren; s_wen = mem_wen;
    chk1("gnt0", m0_if.gnt, w == 0);
    chk1("gnt1", m1_if.gnt, w == 1);
    chk1("mem_ren", mem_ren, e_ren);
    chk1("mem_wen", mem_wen, e_wen);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_wmask", 32'(mem_wmask), 32'(e_wmask));
    @(posedge clk);
    if (w >= 0) begin
      rd = '0;
      if (!rq[w].we && !oor) rd = ref_mem[word[9:0]];
      if (w == 0) exp0_q.push_back({oor, rd});
      else        exp1_q.push_back({oor, rd});
      if (rq[w].we && !oor) begin
        for (int k = 0; k < 4; k++) begin
          if (rq[w].wmask[k]) ref_mem[word[9:0]][8*k +: 8] = rq[w].wdata[8*k +: 8];
        end
      end
    end
    if (owner >= 0) begin
      if (!rq[owner].req || !rq[owner].lock || held >= int'(LOCK_MAX)) begin
        owner = -1;
        held  = 0;
      end else begin
        held++;
      end
    end else if (w >= 0 && rq[w].lock) begin
      owner = w;
      held  = 1;
    end
    if (w >= 0) last = w;
    #1;
    chk1("m0_rvalid", m0_if.rvalid, w == 0);
    chk1("m1_rvalid", m1_if.rvalid, w == 1);
    if (w == 0) begin
      e = exp0_q.pop_front();
      chk("m0_rdata", m0_if.rdata, e[31:0]);
      chk1("m0_err", m0_if.err, e[32]);
    end else if (w == 1) begin
      e = exp1_q.pop_front();
      chk("m1_rdata", m1_if.rdata, e[31:0]);
      chk1("m1_err", m1_if.err, e[32]);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    owner = -1; held = 0; last = 1;
    exp0_q.delete(); exp1_q.delete();
  endtask

  task automatic lock_seq(input int n_more);
    step(idle_r, mk(1, 0, 32'h40, 0, 0, 1));
    chk1("lock_entry_gnt1", s_g1, 1'b1);
    for (int i = 1; i <= n_more + 1; i++) begin
      step(mk(1, 0, 32'h44, 0, 0, 0), mk(1, 0, 32'h40 + 32'(4 * i), 0, 0, i <= n_more));
      chk1($sformatf("lock%0d_hold%0d_gnt0", n_more, i), s_g0, 1'b0);
      chk1($sformatf("lock%0d_hold%0d_gnt1", n_more, i), s_g1, 1'b1);
    end
    step(mk(1, 0, 32'h44, 0, 0, 0), mk(1, 0, 32'h48, 0, 0, 0));
    chk1($sformatf("lock%0d_release_gnt0", n_more), s_g0, 1'b1);
  endtask

  task automatic timeout_seq();
    int first;
    first = -1;
    step(idle_r, mk(1, 0, 32'h60, 0, 0, 1));
    chk1("timeout_entry_gnt1", s_g1, 1'b1);
    for (int k = 1; k <= 8 && first < 0; k++) begin
      step(mk(1, 0, 32'h64, 0, 0, 0), mk(1, 0, 32'h60, 0, 0, 1));
      if (s_g0) first = k;
    end
    chk("timeout_first_m0_gnt_cycle", 32'(first), 32'd5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_r = mk(0, 0, 0, 0, 0, 0);
    rst_n  = 1'b0;
    drive(mk(1, 0, 32'h14, 0, 0, 1), mk(1, 1, 32'h18, 32'h1, 4'hF, 1));
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    mem[5] <= 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    mem[3] <= 32'hAABBCCDD; ref_mem[3] = 32'hAABBCCDD;
    model_reset();

    // vector table
    for (int i = 0; i < 4; i++) begin
      vt[i].r0 = mk(1, 0, 32'h28, 0, 0, 0);
      vt[i].r1 = mk(1, 0, 32'h2C, 0, 0, 0);
      vt[i].g0 = RR ? (i % 2 == 0) : 1'b1;
      vt[i].g1 = !vt[i].g0;
      vt[i].ren = 1'b1; vt[i].wen = 1'b0;
    end
    vt[4] = '{mk(1, 1, 32'h50, 32'hCAFEF00D, 4'hF, 0), idle_r, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{idle_r, mk(1, 0, 32'h50, 0, 0, 0), 1'b0, 1'b1, 1'b1, 1'b0};
    vt[6] = '{idle_r, idle_r, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{mk(1, 0, 32'h1000, 0, 0, 0), idle_r, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8] = '{idle_r, mk(1, 1, 32'hFFFF_FFF0, 32'h5, 4'hF, 0), 1'b0, 1'b1, 1'b0, 1'b0};

    // outputs held quiet during reset even with both masters requesting
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_gnt0", m0_if.gnt, 1'b0);
    chk1("rst_gnt1", m1_if.gnt, 1'b0);
    chk1("rst_mem_ren", mem_ren, 1'b0);
    chk1("rst_mem_wen", mem_wen, 1'b0);
    chk1("rst_m0_rvalid", m0_if.rvalid, 1'b0);
    chk1("rst_m1_rvalid", m1_if.rvalid, 1'b0);
    chk1("rst_m0_err", m0_if.err, 1'b0);
    chk("rst_m0_rdata", m0_if.rdata, 32'h0);
    drive(idle_r, idle_r);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(vt[i].r0, vt[i].r1);
      chk1($sformatf("vec%0d_gnt0", i), s_g0, vt[i].g0);
      chk1($sformatf("vec%0d_gnt1", i), s_g1, vt[i].g1);
      chk1($sformatf("vec%0d_ren", i), s_ren, vt[i].ren);
      chk1($sformatf("vec%0d_wen", i), s_wen, vt[i].wen);
    end

    // single read of word 5
    step(mk(1, 0, 32'h14, 0, 0, 0), idle_r);
    chk1("single_read_gnt0", s_g0, 1'b1);
    chk1("single_read_rvalid", m0_if.rvalid, 1'b1);
    chk("single_read_rdata", m0_if.rdata, 32'hDEADBEEF);
    chk1("single_read_err", m0_if.err, 1'b0);

    // masked write then read-back of word 3
    step(idle_r, mk(1, 1, 32'h0C, 32'h11223344, 4'b0101, 0));
    chk1("wr_gnt1", s_g1, 1'b1);
    chk1("wr_ack_rvalid", m1_if.rvalid, 1'b1);
    chk("wr_ack_rdata", m1_if.rdata, 32'h0);
    step(idle_r, mk(1, 0, 32'h0C, 0, 0, 0));
    chk("rd_after_wr_rdata", m1_if.rdata, 32'hAA22CC44);

    // out of range read
    step(mk(1, 0, 32'h1000, 0, 0, 0), idle_r);
    chk1("oor_gnt0", s_g0, 1'b1);
    chk1("oor_mem_ren", s_ren, 1'b0);
    chk1("oor_rvalid", m0_if.rvalid, 1'b1);
    chk1("oor_err", m0_if.err, 1'b1);
    chk("oor_rdata", m0_if.rdata, 32'h0);

    lock_seq(3);
    lock_seq(1);
    timeout_seq();
    step(idle_r, idle_r);

    // reset mid-lock: pending response dropped, lock cleared
    step(idle_r, mk(1, 0, 32'h20, 0, 0, 1));
    step(idle_r, mk(1, 0, 32'h24, 0, 0, 1));
    drive(idle_r, idle_r);
    rst_n = 1'b0;
    #1;
    chk1("midrst_m1_rvalid_dropped", m1_if.rvalid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1, 0, 32'h30, 0, 0, 0), mk(1, 0, 32'h34, 0, 0, 1));
    chk1("midrst_lock_cleared_gnt0", s_g0, 1'b1);

    // random traffic; masters hold payload until granted
    has0 = 0; has1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!has0 && $urandom_range(0, 3) != 0) begin pend0 = rand_req(); has0 = 1; end
      if (!has1 && $urandom_range(0, 3) != 0) begin pend1 = rand_req(); has1 = 1; end
      a0 = idle_r; a1 = idle_r;
      if (has0) a0 = pend0;
      if (has1) a1 = pend1;
      step(a0, a1);
      if (s_g0) has0 = 0;
      if (s_g1) has1 = 0;
    end
    step(idle_r, idle_r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
